// File: rtl/uart_console_pkg.sv
// Shared FSM encoding and defaults for the console UART.
// Defining UART_CONSOLE_PARITY_EN adds the even-parity state (8E1 frames).
package uart_console_pkg;

  localparam logic [7:0]  CONSOLE_ADDR_DEF = 8'hFF;
  localparam int unsigned UART_DIV_DEF     = 434;

`ifdef UART_CONSOLE_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} txState_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} txState_t;
`endif

endpackage

// File: rtl/uart_console_if.sv
// MEM-stage store snoop bus feeding the console sink.
interface uart_console_if;
  logic        wren;
  logic [7:0]  addr;
  logic [31:0] din;

  modport master (output wren, addr, din);
  modport slave  (input  wren, addr, din);
endinterface

// File: rtl/uart_console_fifo.sv
// Synchronous FIFO buffering console bytes between store snooping and the TX FSM.
module console_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [PtrW:0]    countQ;
  logic             doPush, doPop;

  assign full   = (countQ == (PtrW+1)'(FIFO_DEPTH));
  assign empty  = (countQ == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdata  = mem[rdPtrQ];
  assign count  = countQ;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
      if (doPush && !doPop)      countQ <= countQ + 1'b1;
      else if (doPop && !doPush) countQ <= countQ - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtrQ] <= wdata;
  end

endmodule

// File: rtl/uart_console.sv
// Console sink: captures byte stores to CONSOLE_ADDR and serialises them as UART frames.
// UART_CONSOLE_PARITY_EN selects 8E1 framing instead of 8N1.
module uart_console
  import uart_console_pkg::*;
#(
  parameter int unsigned CLK_DIV      = UART_DIV_DEF,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
  input  logic           clock,
  input  logic           reset,
  uart_console_if.slave  bus,
  output logic           tx,
  output logic           busy,
  output logic           full,
  output logic           overflow
);

  localparam int unsigned      BaudW    = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLK_DIV - 1);

  txState_t                    stateQ, stateD;
  logic [BaudW-1:0]            baudQ, baudD;
  logic [2:0]                  bitIdxQ, bitIdxD;
  logic [7:0]                  shiftQ, shiftD;
  logic                        overflowQ;
  logic                        hit, push, pop;
  logic                        fifoFull, fifoEmpty;
  logic [7:0]                  fifoData;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic                        unusedDin;
`ifdef UART_CONSOLE_PARITY_EN
  logic                        parityQ, parityD;
`endif

  assign hit       = bus.wren && (bus.addr == CONSOLE_ADDR);
  assign push      = hit && !fifoFull;
  assign unusedDin = ^bus.din[31:8];

  console_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.din[7:0]),
    .rdata (fifoData),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateQ <= ST_IDLE;
    else       stateQ <= stateD;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baudQ     <= '0;
      bitIdxQ   <= '0;
      shiftQ    <= '0;
      overflowQ <= 1'b0;
`ifdef UART_CONSOLE_PARITY_EN
      parityQ   <= 1'b0;
`endif
    end else begin
      baudQ   <= baudD;
      bitIdxQ <= bitIdxD;
      shiftQ  <= shiftD;
`ifdef UART_CONSOLE_PARITY_EN
      parityQ <= parityD;
`endif
      if (hit && fifoFull) overflowQ <= 1'b1;
    end
  end

  always_comb begin
    stateD  = stateQ;
    baudD   = baudQ;
    bitIdxD = bitIdxQ;
    shiftD  = shiftQ;
    pop     = 1'b0;
`ifdef UART_CONSOLE_PARITY_EN
    parityD = parityQ;
`endif
    unique case (stateQ)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          pop    = 1'b1;
          shiftD = fifoData;
          baudD  = BaudLoad;
          stateD = ST_START;
`ifdef UART_CONSOLE_PARITY_EN
          parityD = ^fifoData;
`endif
        end
      end
      ST_START: begin
        if (baudQ == '0) begin
          baudD   = BaudLoad;
          bitIdxD = '0;
          stateD  = ST_DATA;
        end else begin
          baudD = baudQ - 1'b1;
        end
      end
      ST_DATA: begin
        if (baudQ == '0) begin
          baudD = BaudLoad;
          if (bitIdxQ == 3'd7) begin
`ifdef UART_CONSOLE_PARITY_EN
            stateD = ST_PARITY;
`else
            stateD = ST_STOP;
`endif
          end else begin
            bitIdxD = bitIdxQ + 1'b1;
            shiftD  = shiftQ >> 1;
          end
        end else begin
          baudD = baudQ - 1'b1;
        end
      end
`ifdef UART_CONSOLE_PARITY_EN
      ST_PARITY: begin
        if (baudQ == '0) begin
          baudD  = BaudLoad;
          stateD = ST_STOP;
        end else begin
          baudD = baudQ - 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baudQ == '0) begin
          // Pop on the last stop cycle so a queued byte starts with no idle gap.
          if (!fifoEmpty) begin
            pop    = 1'b1;
            shiftD = fifoData;
            baudD  = BaudLoad;
            stateD = ST_START;
`ifdef UART_CONSOLE_PARITY_EN
            parityD = ^fifoData;
`endif
          end else begin
            stateD = ST_IDLE;
          end
        end else begin
          baudD = baudQ - 1'b1;
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (stateQ)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shiftQ[0];
`ifdef UART_CONSOLE_PARITY_EN
      ST_PARITY: tx = parityQ;
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign busy     = (stateQ != ST_IDLE) || (fifoCount != '0);
  assign full     = fifoFull;
  assign overflow = overflowQ;

endmodule
